// File: rtl/reg_sipo_pkg.sv
// rtl/reg_sipo_pkg.sv - shared widths and FSM state type for the SIPO register-file slice
package reg_sipo_pkg;

  localparam int ADSize      = 5;
  localparam int DASize      = 8;
  localparam int STP_REGSize = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WIN   = 3'd3,
    DONE  = 3'd4
  } sipo_state_t;

endpackage

// File: rtl/reg_sipo_32x8.sv
// rtl/reg_sipo_32x8.sv - 32-entry register file with a three-register sliding window read port
module reg_sipo_32x8 #(
  parameter int ADSize = 5,
  parameter int DASize = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              Write,
  input  logic              Read,
  input  logic [DASize-1:0] DIN,
  input  logic [ADSize-1:0] Write_ADDR,
  input  logic [ADSize-1:0] Read_ADDR,
  output logic [DASize-1:0] OUT_1,
  output logic [DASize-1:0] OUT_2,
  output logic [DASize-1:0] OUT_3
);
  import reg_sipo_pkg::*;

  logic [DASize-1:0] mem [0:STP_REGSize-1];
  logic [ADSize-1:0] rd_addr_1;
  logic [ADSize-1:0] rd_addr_2;

  assign rd_addr_1 = Read_ADDR + ADSize'(1);
  assign rd_addr_2 = Read_ADDR + ADSize'(2);

  // Storage array: written by the controller's write strobe, no reset needed.
  always_ff @(posedge clk) begin
    if (enable && Write) begin
      mem[Write_ADDR] <= DIN;
    end
  end

  // Window registers: capture three consecutive entries on the read strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      OUT_1 <= '0;
      OUT_2 <= '0;
      OUT_3 <= '0;
    end else if (enable && Read) begin
      OUT_1 <= mem[Read_ADDR];
      OUT_2 <= mem[rd_addr_1];
      OUT_3 <= mem[rd_addr_2];
    end
  end

endmodule

// File: rtl/reg_sipo_sys.sv
// rtl/reg_sipo_sys.sv - wrapper joining the frame controller to the 32x8 register file (SIPO_CTRL_STATS_EN adds counters)
module reg_sipo_sys #(
  parameter int ADSize    = 5,
  parameter int DASize    = 8,
  parameter int FRAME_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DASize-1:0] in_data,
  output logic              in_ready,
  input  logic              win_ready,
  output logic              win_valid,
  output logic [ADSize-1:0] win_base,
  output logic              done,
  output logic [DASize-1:0] OUT_1,
  output logic [DASize-1:0] OUT_2,
  output logic [DASize-1:0] OUT_3
`ifdef SIPO_CTRL_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       win_cnt
`endif
);

  logic              enable;
  logic              wr;
  logic              rd;
  logic [DASize-1:0] din;
  logic [ADSize-1:0] wr_addr;
  logic [ADSize-1:0] rd_addr;

  reg_sipo_ctrl #(
    .ADSize   (ADSize),
    .DASize   (DASize),
    .FRAME_LEN(FRAME_LEN)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .win_ready (win_ready),
    .win_valid (win_valid),
    .win_base  (win_base),
    .done      (done),
    .enable    (enable),
    .Write     (wr),
    .Read      (rd),
    .DIN       (din),
    .Write_ADDR(wr_addr),
    .Read_ADDR (rd_addr)
`ifdef SIPO_CTRL_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .win_cnt   (win_cnt)
`endif
  );

  reg_sipo_32x8 #(
    .ADSize(ADSize),
    .DASize(DASize)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .Write     (wr),
    .Read      (rd),
    .DIN       (din),
    .Write_ADDR(wr_addr),
    .Read_ADDR (rd_addr),
    .OUT_1     (OUT_1),
    .OUT_2     (OUT_2),
    .OUT_3     (OUT_3)
  );

endmodule

// File: rtl/reg_sipo_ctrl.sv
// rtl/reg_sipo_ctrl.sv - frame FSM streaming bytes into the register file and presenting 3-byte windows (SIPO_CTRL_STATS_EN adds counters)
module reg_sipo_ctrl #(
  parameter int ADSize    = 5,
  parameter int DASize    = 8,
  parameter int FRAME_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DASize-1:0] in_data,
  output logic              in_ready,
  input  logic              win_ready,
  output logic              win_valid,
  output logic [ADSize-1:0] win_base,
  output logic              done,
  output logic              enable,
  output logic              Write,
  output logic              Read,
  output logic [DASize-1:0] DIN,
  output logic [ADSize-1:0] Write_ADDR,
  output logic [ADSize-1:0] Read_ADDR
`ifdef SIPO_CTRL_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       win_cnt
`endif
);
  import reg_sipo_pkg::*;

  // Byte counter wide enough to hold FRAME_LEN itself.
  localparam int CW = $clog2(FRAME_LEN + 1);

  sipo_state_t       state;
  logic [ADSize-1:0] wr_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_inc;
  logic [ADSize-1:0] base_q;
  logic [ADSize-1:0] oldest_addr;
  logic              wr_hs;

  assign wr_hs       = (state == WRITE) && in_valid;
  assign count_inc   = count + CW'(1);
  // Oldest of the last three bytes written; never wraps for a legal frame.
  assign oldest_addr = wr_ptr - ADSize'(3);

  // Frame sequencing: abort wins over every other transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      count  <= '0;
      base_q <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= WRITE;
            wr_ptr <= '0;
            count  <= '0;
          end
        end
        WRITE: begin
          if (in_valid) begin
            wr_ptr <= wr_ptr + ADSize'(1);
            count  <= count_inc;
            if (count_inc >= CW'(3)) begin
              state <= READ;
            end
          end
        end
        READ: begin
          base_q <= oldest_addr;
          state  <= WIN;
        end
        WIN: begin
          if (win_ready) begin
            state <= (count == CW'(FRAME_LEN)) ? DONE : WRITE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode from the registered state; datapath fields are zero unless strobed.
  always_comb begin
    in_ready   = (state == WRITE);
    win_valid  = (state == WIN);
    win_base   = (state == WIN) ? base_q : '0;
    done       = (state == DONE);
    enable     = (state != IDLE);
    Write      = wr_hs;
    DIN        = wr_hs ? in_data : '0;
    Write_ADDR = wr_hs ? wr_ptr : '0;
    Read       = (state == READ);
    Read_ADDR  = (state == READ) ? oldest_addr : '0;
  end

`ifdef SIPO_CTRL_STATS_EN
  // Free-running wrap-around statistics, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      win_cnt   <= '0;
    end else begin
      if (state == DONE) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if ((state == WIN) && win_ready) begin
        win_cnt <= win_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/reg_sipo_ctrl.md
REG_SIPO_CTRL -- requirements
Module: reg_sipo_ctrl

Interface
REQ-001 The block SHALL have parameter ADSize, default 5, register-file address width.
REQ-002 The block SHALL have parameter DASize, default 8, data width.
REQ-003 The block SHALL have parameter FRAME_LEN, default 8, bytes per frame; legal range 3..32.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
 clk  in  1  clock, all state on rising edge
 rst  in  1  asynchronous active-low reset
 start  in  1  one-cycle pulse, begins a frame, honoured only in IDLE
 abort  in  1  synchronous frame cancel
 in_valid  in  1  input byte present
 in_data  in  DASize  input byte
 in_ready  out  1  byte accepted when in_valid && in_ready
 win_ready  in  1  consumer accepts the current window
 win_valid  out  1  register-file OUT_1..OUT_3 hold a valid 3-byte window
 win_base  out  ADSize  address of OUT_1 for the current window
 done  out  1  one-cycle pulse, frame complete
 enable  out  1  register-file enable
 Write  out  1  register-file write strobe
 Read  out  1  register-file read strobe
 DIN  out  DASize  register-file write data
 Write_ADDR  out  ADSize  register-file write address
 Read_ADDR  out  ADSize  register-file read address

Function
REQ-005 The FSM SHALL have states IDLE, WRITE, READ, WIN and DONE.
REQ-006 IDLE SHALL go to WRITE on start; wr_ptr and count SHALL be cleared to 0.
REQ-007 In WRITE, in_ready SHALL be 1.
REQ-008 On a WRITE handshake, the block SHALL drive, combinationally in the same cycle, Write=1, DIN=in_data and Write_ADDR=wr_ptr, and SHALL then increment wr_ptr and count.
REQ-009 A WRITE handshake SHALL go to READ if the new count is >=3, and SHALL otherwise stay in WRITE.
REQ-010 Read SHALL be 1 in READ, with Read_ADDR=wr_ptr-3 (the oldest of the last three bytes); READ SHALL then go to WIN.
REQ-011 Write and Read SHALL never both be 1 in the same cycle; in_ready SHALL be 0 in every state except WRITE.
REQ-012 The register file is taken to latch OUT_1..OUT_3 on the edge that ends READ; win_valid SHALL be 1 throughout WIN, one cycle after READ.
REQ-013 win_base SHALL equal the Read_ADDR of the preceding READ and SHALL stay stable while win_valid is 1.
REQ-014 WIN SHALL hold until win_ready=1; it SHALL then go to DONE if count==FRAME_LEN, and to WRITE otherwise.
REQ-015 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-016 A frame SHALL produce exactly FRAME_LEN-2 windows, with win_base values 0..FRAME_LEN-3; addresses SHALL never wrap.
REQ-017 enable SHALL be 1 in every state except IDLE.
REQ-018 Outside a WRITE handshake, DIN, Write_ADDR and Read_ADDR SHALL be 0 except as stated above.
REQ-019 abort SHALL force IDLE on the next edge from any state, with no done pulse; abort has priority over all other transitions.
REQ-020 start in any state other than IDLE SHALL be ignored; start and abort in the same cycle SHALL leave the block in IDLE.

Reset
REQ-021 While rst=0, the block SHALL be in state IDLE with wr_ptr=0, count=0 and all outputs 0.
REQ-022 Reset asserted mid-frame SHALL discard the frame; no done pulse SHALL follow.

Configuration
REQ-023 With SIPO_CTRL_STATS_EN defined, the block SHALL add outputs frame_cnt[15:0] (incremented on done) and win_cnt[15:0] (incremented on each win_valid && win_ready); both SHALL wrap and be cleared by reset only.
REQ-024 Without SIPO_CTRL_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-025 Package reg_sipo_pkg SHALL hold ADSize, DASize and STP_REGSize=32, plus the FSM state enum, shared with reg_sipo_32x8.
REQ-026 The block SHALL be a single FSM module with no sub-module; a top-level wrapper SHALL instantiate reg_sipo_ctrl together with reg_sipo_32x8.

Verification
REQ-027 Reset then start, FRAME_LEN=8, stream bytes 1..8 with win_ready=1 -> 6 windows with win_base 0..5, OUT_1..3 = (1,2,3) .. (6,7,8), then done once.
REQ-028 Hold win_ready=0 for 5 cycles at the first window -> win_valid and win_base=0 held stable, in_ready=0, no Write.
REQ-029 in_valid toggling 1,0,1,0 in WRITE -> Write only on handshake cycles; Write_ADDR increments 0,1,2 with no gaps.
REQ-030 abort after 4 bytes, then start again -> IDLE with no done; the new frame writes from address 0.
REQ-031 rst=0 asserted mid-WIN -> all outputs 0 immediately; win_valid deasserts asynchronously.
REQ-032 FRAME_LEN=32 run -> last window has win_base=29 and Write_ADDR reaches 31; with SIPO_CTRL_STATS_EN, win_cnt=30 and frame_cnt=1.
